// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: state encodings and ring ordering shared by the
// moore_seq_param sequencer and its dwell counter.
package moore_seq_pkg;

  // 3-bit state encodings; 6 and 7 are unused and treated as illegal.
  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_A    = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_DIFF = 3'd4;
  localparam logic [2:0] S_MAX  = 3'd5;

  // Ring direction values.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Next state around the ring. Forward is LOAD->A->B->SUM->DIFF->MAX->LOAD,
  // reverse walks the same ring backwards. Any illegal code recovers to LOAD.
  function automatic logic [2:0] state_next(input logic [2:0] state, input logic dir);
    logic [2:0] nxt;
    case (state)
      S_LOAD:  nxt = (dir == DIR_REV) ? S_MAX  : S_A;
      S_A:     nxt = (dir == DIR_REV) ? S_LOAD : S_B;
      S_B:     nxt = (dir == DIR_REV) ? S_A    : S_SUM;
      S_SUM:   nxt = (dir == DIR_REV) ? S_B    : S_DIFF;
      S_DIFF:  nxt = (dir == DIR_REV) ? S_SUM  : S_MAX;
      S_MAX:   nxt = (dir == DIR_REV) ? S_DIFF : S_LOAD;
      default: nxt = S_LOAD;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/moore_dwell_cnt.sv
// moore_dwell_cnt: counts 0..DWELL-1 within a state and flags the last
// cycle (tc). hold freezes the count; clr forces it back to zero.
module moore_dwell_cnt #(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic clr,
  output logic tc
);

  // A single-cycle dwell still needs a one-bit counter that never moves.
  localparam int unsigned CW = (DWELL > 32'd1) ? $clog2(DWELL) : 32'd1;
  localparam logic [CW-1:0] TERM = CW'(DWELL - 32'd1);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  assign tc = (cnt_q == TERM);

  // Next count: clear wins, then hold freezes, then wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (tc) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(32'd1);
    end
  end

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/moore_seq_param.sv
// moore_seq_param: parametrised Moore sequencer. Latches two operands when
// leaving LOAD and walks a ring of output states (A, B, sum, difference,
// unsigned max), dwelling DWELL cycles in each. All outputs are registered.
module moore_seq_param
  import moore_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned DWELL  = 1,
  parameter int unsigned REV_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag,
  input  logic             hold,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       state_o,
  output logic             wrap
);

  localparam logic REV_ON = (REV_EN != 32'd0);

  logic [2:0]       state_d;
  logic [2:0]       state_q;
  logic [WIDTH-1:0] ra_d;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_d;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             wrap_d;
  logic             wrap_q;

  logic             tc_s;
  logic             illegal_s;
  logic             dir_s;
  logic             advance_s;

  // Output value for a given state and operand pair; arithmetic wraps
  // modulo 2^WIDTH and max favours ra on a tie.
  function automatic logic [WIDTH-1:0] decode(input logic [2:0] st,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] v;
    case (st)
      S_LOAD:  v = {WIDTH{1'b0}};
      S_A:     v = x;
      S_B:     v = y;
      S_SUM:   v = x + y;
      S_DIFF:  v = x - y;
      S_MAX:   v = (x >= y) ? x : y;
      default: v = {WIDTH{1'b0}};
    endcase
    return v;
  endfunction

  // Illegal codes escape to LOAD on the next edge regardless of hold.
  assign illegal_s = (state_q > S_MAX);
  assign dir_s     = REV_ON ? flag : DIR_FWD;
  assign advance_s = tc_s & ~hold;

  moore_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .clr   (illegal_s),
    .tc    (tc_s)
  );

  // Next state and operand capture; operands load only on the LOAD exit edge.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    if (illegal_s) begin
      state_d = S_LOAD;
    end else if (advance_s) begin
      if (state_q == S_LOAD) begin
        ra_d = a;
        rb_d = b;
      end else begin
        ra_d = ra_q;
        rb_d = rb_q;
      end
      state_d = state_next(state_q, dir_s);
    end else begin
      state_d = state_q;
    end
  end

  // Output decode from the next state so out moves on the same edge as the
  // state; wrap marks the edge that re-enters LOAD from elsewhere.
  always_comb begin
    out_d  = decode(state_d, ra_d, rb_d);
    wrap_d = (state_d == S_LOAD) && (state_q != S_LOAD);
  end

  // State, operand and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      ra_q    <= {WIDTH{1'b0}};
      rb_q    <= {WIDTH{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out     = out_q;
  assign state_o = state_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_moore_seq_param.sv
// tb_moore_seq_param: table-driven and randomized self-checking bench for
// moore_seq_param. Four instances with different parameters share stimulus;
// a ring-position reference model predicts every instance.
module tb_moore_seq_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flag = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] a_in = 8'd0;
  logic [7:0] b_in = 8'd0;

  logic [2:0] out_0, out_1, out_3;
  logic [7:0] out_2;
  logic [2:0] st_0, st_1, st_2, st_3;
  logic       wr_0, wr_1, wr_2, wr_3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  moore_seq_param #(.WIDTH(3), .DWELL(1), .REV_EN(1)) u0 (
    .clk(clk), .reset(reset), .flag(flag), .hold(hold),
    .a(a_in[2:0]), .b(b_in[2:0]), .out(out_0), .state_o(st_0), .wrap(wr_0));
  moore_seq_param #(.WIDTH(3), .DWELL(3), .REV_EN(1)) u1 (
    .clk(clk), .reset(reset), .flag(flag), .hold(hold),
    .a(a_in[2:0]), .b(b_in[2:0]), .out(out_1), .state_o(st_1), .wrap(wr_1));
  moore_seq_param #(.WIDTH(8), .DWELL(1), .REV_EN(1)) u2 (
    .clk(clk), .reset(reset), .flag(flag), .hold(hold),
    .a(a_in), .b(b_in), .out(out_2), .state_o(st_2), .wrap(wr_2));
  moore_seq_param #(.WIDTH(3), .DWELL(2), .REV_EN(0)) u3 (
    .clk(clk), .reset(reset), .flag(flag), .hold(hold),
    .a(a_in[2:0]), .b(b_in[2:0]), .out(out_3), .state_o(st_3), .wrap(wr_3));

  // ---------------- reference model ----------------
  // Ring positions 0..5 name LOAD, A, B, SUM, DIFF, MAX in forward order.
  localparam int MW[4] = '{3, 3, 8, 3};
  localparam int MD[4] = '{1, 3, 1, 2};
  localparam int MR[4] = '{1, 1, 1, 0};
  int m_pos[4], m_cnt[4], m_ra[4], m_rb[4], m_out[4], m_wrap[4];

  function automatic int model_val(input int pos, input int ra, input int rb, input int modv);
    if (pos == 1) return ra;
    if (pos == 2) return rb;
    if (pos == 3) return (ra + rb) % modv;
    if (pos == 4) return (ra - rb + modv) % modv;
    if (pos == 5) return (ra >= rb) ? ra : rb;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_pos[m] = 0; m_cnt[m] = 0; m_ra[m] = 0; m_rb[m] = 0;
      m_out[m] = 0; m_wrap[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 4; m++) begin
      int modv;
      modv = 1 << MW[m];
      if (hold) begin
        m_wrap[m] = 0;
      end else if (m_cnt[m] == MD[m] - 1) begin
        m_cnt[m] = 0;
        if (m_pos[m] == 0) begin
          m_ra[m] = int'(a_in) % modv;
          m_rb[m] = int'(b_in) % modv;
        end
        if (MR[m] != 0 && flag) m_pos[m] = (m_pos[m] + 5) % 6;
        else                    m_pos[m] = (m_pos[m] + 1) % 6;
        m_wrap[m] = (m_pos[m] == 0) ? 1 : 0;
        m_out[m]  = model_val(m_pos[m], m_ra[m], m_rb[m], modv);
      end else begin
        m_cnt[m]  = m_cnt[m] + 1;
        m_wrap[m] = 0;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input int m, input int o, input int s, input int w);
    check($sformatf("u%0d_out", m), o, m_out[m]);
    check($sformatf("u%0d_state", m), s, m_pos[m]);
    check($sformatf("u%0d_wrap", m), w, m_wrap[m]);
  endtask

  task automatic check_models();
    cmp_model(0, int'(out_0), int'(st_0), int'(wr_0));
    cmp_model(1, int'(out_1), int'(st_1), int'(wr_1));
    cmp_model(2, int'(out_2), int'(st_2), int'(wr_2));
    cmp_model(3, int'(out_3), int'(st_3), int'(wr_3));
  endtask

  // One clock edge with the given inputs; returns at the following negedge.
  task automatic step(input logic f, input logic h, input logic [7:0] av, input logic [7:0] bv);
    flag = f; hold = h; a_in = av; b_in = bv;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset across one rising edge, released at a falling edge.
  task automatic do_reset();
    flag = 1'b0; hold = 1'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       flag;
    logic       hold;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic [2:0] exp_state;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkv(input logic f, input logic [7:0] o, input logic [2:0] s, input logic w);
    vec_t v;
    v.flag = f; v.hold = 1'b0; v.a = 8'd5; v.b = 8'd6;
    v.exp_out = o; v.exp_state = s; v.exp_wrap = w;
    return v;
  endfunction

  int w8_exp[11] = '{200, 100, 44, 100, 200, 0, 7, 7, 14, 0, 7};

  initial begin
    // Forward ring then reverse ring for WIDTH=3, DWELL=1, a=5, b=6.
    vecs[0]  = mkv(1'b0, 8'd5, 3'd1, 1'b0);
    vecs[1]  = mkv(1'b0, 8'd6, 3'd2, 1'b0);
    vecs[2]  = mkv(1'b0, 8'd3, 3'd3, 1'b0);
    vecs[3]  = mkv(1'b0, 8'd7, 3'd4, 1'b0);
    vecs[4]  = mkv(1'b0, 8'd6, 3'd5, 1'b0);
    vecs[5]  = mkv(1'b0, 8'd0, 3'd0, 1'b1);
    vecs[6]  = mkv(1'b1, 8'd6, 3'd5, 1'b0);
    vecs[7]  = mkv(1'b1, 8'd7, 3'd4, 1'b0);
    vecs[8]  = mkv(1'b1, 8'd3, 3'd3, 1'b0);
    vecs[9]  = mkv(1'b1, 8'd6, 3'd2, 1'b0);
    vecs[10] = mkv(1'b1, 8'd5, 3'd1, 1'b0);
    vecs[11] = mkv(1'b1, 8'd0, 3'd0, 1'b1);

    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_out", int'(out_0), 0);
    check("reset_state", int'(st_0), 0);
    check("reset_wrap", int'(wr_0), 0);
    reset = 1'b1;

    // Table: forward and reverse ring on u0, all instances against model.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].flag, vecs[i].hold, vecs[i].a, vecs[i].b);
      check($sformatf("tbl%0d_out", i), int'(out_0), int'(vecs[i].exp_out));
      check($sformatf("tbl%0d_state", i), int'(st_0), int'(vecs[i].exp_state));
      check($sformatf("tbl%0d_wrap", i), int'(wr_0), int'(vecs[i].exp_wrap));
      check_models();
    end

    // Reverse to SUM, then flag=0 continues forward to DIFF.
    step(1'b1, 1'b0, 8'd5, 8'd6);
    step(1'b1, 1'b0, 8'd5, 8'd6);
    step(1'b1, 1'b0, 8'd5, 8'd6);
    check("rev_at_sum", int'(st_0), 3);
    step(1'b0, 1'b0, 8'd5, 8'd6);
    check("turn_state", int'(st_0), 4);
    check("turn_out", int'(out_0), 7);

    // Operand change mid-ring is ignored until the next LOAD exit.
    begin
      int exp_o[7] = '{6, 0, 2, 1, 3, 1, 2};
      for (int i = 0; i < 7; i++) begin
        step(1'b0, 1'b0, 8'd2, 8'd1);
        check($sformatf("iso%0d_out", i), int'(out_0), exp_o[i]);
        check_models();
      end
    end

    // Hold in LOAD: no capture, no wrap; capture happens when hold drops.
    do_reset();
    step(1'b0, 1'b1, 8'd1, 8'd2);
    step(1'b0, 1'b1, 8'd1, 8'd2);
    check("holdload_state", int'(st_0), 0);
    check("holdload_wrap", int'(wr_0), 0);
    step(1'b0, 1'b0, 8'd3, 8'd4);
    check("holdload_out", int'(out_0), 3);
    check_models();

    // Async reset mid-ring at SUM, then first edge after release.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd5, 8'd6);
    check("pre_rst_state", int'(st_0), 3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_out", int'(out_0), 0);
    check("async_rst_state", int'(st_0), 0);
    check("async_rst_wrap", int'(wr_0), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 8'd5, 8'd6);
    check("post_rst_state", int'(st_0), 1);
    check("post_rst_out", int'(out_0), 5);

    // DWELL=3 with hold for 4 cycles while in B (u1).
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      int es, eo;
      es = (i < 3) ? 0 : (i < 6) ? 1 : (i < 13) ? 2 : 3;
      eo = (i < 3) ? 0 : (i < 6) ? 5 : (i < 13) ? 6 : 3;
      step(1'b0, (i >= 9 && i <= 12), 8'd5, 8'd6);
      check($sformatf("dwell%0d_state", i), int'(st_1), es);
      check($sformatf("dwell%0d_out", i), int'(out_1), eo);
      check_models();
    end

    // WIDTH=8 edge arithmetic (u2).
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b0, (i < 6) ? 8'd200 : 8'd7, (i < 6) ? 8'd100 : 8'd7);
      check($sformatf("w8_%0d_out", i), int'(out_2), w8_exp[i]);
      check_models();
    end

    // Randomized stimulus against the model, with occasional async resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(63, 0) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
      end
      step(1'($urandom_range(1, 0)), ($urandom_range(4, 0) == 0),
           8'($urandom), 8'($urandom));
      check_models();
    end

    // Illegal state 6 forced on u2 while in B recovers to LOAD, out=0.
    do_reset();
    step(1'b0, 1'b0, 8'd7, 8'd7);
    step(1'b0, 1'b0, 8'd7, 8'd7);
    check("pre_illegal_state", int'(st_2), 2);
    force u2.state_q = 3'd6;
    #1;
    release u2.state_q;
    @(posedge clk);
    @(negedge clk);
    check("illegal_state", int'(st_2), 0);
    check("illegal_out", int'(out_2), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
